// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind the core's load/store port with wait states and byte lanes.
// Optional: define DMEM_BOUNDS_CHECK_EN to flag addresses beyond the RAM as errors instead of wrapping.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic        datamem_rd,
  input  logic        datamem_wr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        err
);

  localparam int unsigned CNT_W    = 4;
  localparam bit          HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [CNT_W-1:0] WAIT_INIT = HAS_WAIT ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         strb_q, strb_d;
  logic               is_wr_q, is_wr_d;
  logic               is_err_q, is_err_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [31:0]        rd_data_q;
  logic               oob_c;
  logic [31:0]        mem_q [DEPTH_WORDS];

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
  logic unused_addr_c;
  assign oob_c         = (data_addr >= ADDR_LIMIT);
  assign unused_addr_c = ^data_addr[1:0];
`else
  logic unused_addr_c;
  assign oob_c         = 1'b0;
  assign unused_addr_c = ^{data_addr[31:ADDR_W+2], data_addr[1:0]};
`endif

  // Next-state, request capture and completion flags
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    is_wr_d  = is_wr_q;
    is_err_d = is_err_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (datamem_rd || datamem_wr) begin
          idx_d    = data_addr[ADDR_W+1:2];
          wdata_d  = wr_data;
          strb_d   = wr_strb;
          is_wr_d  = datamem_wr;
          is_err_d = (datamem_rd && datamem_wr) || oob_c;
          if (HAS_WAIT) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        err_d   = is_err_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      is_wr_q  <= 1'b0;
      is_err_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      is_wr_q  <= is_wr_d;
      is_err_q <= is_err_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  // Read data is captured on the completing edge and held afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (state_q == S_RESP) begin
      if (is_err_q) begin
        rd_data_q <= '0;
      end else if (!is_wr_q) begin
        rd_data_q <= mem_q[idx_q];
      end
    end
  end

  // RAM is not reset; a commit coinciding with rst is dropped
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_RESP && is_wr_q && !is_err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_q;
  assign ready   = ready_q;
  assign err     = err_q;

endmodule
